mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Uses valid/ready handshakes on every channel and allows one outstanding transaction at a time.
- Sits between IFU/LSU and the memory/bus bridge. The LSU is driven by the decoder's readMemEnable, writeMemEnable and memOP signals.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT_CYCLES, 255, response wait limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  IFU response valid
ifu_resp_ready  in  1  IFU can take response
ifu_rdata  out  DATA_W  fetched instruction word
ifu_resp_err  out  1  IFU access error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  LSU response valid
lsu_resp_ready  in  1  LSU can take response
lsu_rdata  out  DATA_W  load data
lsu_resp_err  out  1  LSU access error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  address
mem_wen  out  1  write enable
mem_wdata  out  DATA_W  write data
mem_wmask  out  DATA_W/8  write mask
mem_resp_valid  in  1  memory response valid
mem_resp_ready  out  1  arbiter takes response
mem_rdata  in  DATA_W  read data
mem_resp_err  in  1  memory error

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE; owner = none; all mem_* request registers = 0.
- Outputs in reset: all valid/ready outputs are 0. rdata outputs and err outputs are 0.
- FSM states: IDLE, REQ, RESP.
- IDLE, arbitration:
  - LSU has fixed priority over IFU.
  - lsu_req_ready = lsu_req_valid.
  - ifu_req_ready = ifu_req_valid & ~lsu_req_valid. Both are combinational, and only in IDLE.
  - When one request is accepted: latch owner and request fields (IFU forces wen = 0 and wmask = 0), then go to REQ.
  - If both requesters are valid, LSU is accepted and IFU sees ready = 0 that cycle.
- REQ:
  - mem_req_valid = 1; mem_addr, mem_wen, mem_wdata and mem_wmask come from registers, so they are stable while valid.
  - On mem_req_ready = 1, go to RESP.
  - Both *_req_ready outputs are 0.
- RESP:
  - mem_resp_ready = owner's resp_ready.
  - Owner's resp_valid = mem_resp_valid; owner's rdata = mem_rdata; owner's err = mem_resp_err.
  - The non-owner's resp_valid = 0.
  - On mem_resp_valid & mem_resp_ready, go to IDLE.
- Latency: request accepted in cycle N → mem_req_valid asserted from cycle N+1. The response passes through combinationally, with zero added cycles.
- Throughput: at most one transaction per 3 cycles with a zero-wait memory. No new acceptance is possible in the cycle the response completes.
- Stores: the response carries no data, and rdata is passed through unchanged.
- Response backpressure: if the owner holds resp_ready = 0, the arbiter stays in RESP and mem_resp_ready = 0.
- Reset mid-transaction: aborts immediately to IDLE. No response is delivered to either requester.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entry to RESP and increments each RESP cycle while mem_resp_valid = 0.
  - When it reaches TIMEOUT_CYCLES, the arbiter enters an internal error-response mode: owner resp_valid = 1, err = 1, rdata = 0, and mem_resp_ready = 0.
  - On the owner handshake, go to IDLE.
  - A later memory response from that transaction is dropped: mem_resp_ready = 1 in IDLE while a stale flag is set; the flag clears on that handshake.
  - The REQ state is never timed out, so a request is never withdrawn.
- Without the macro: the arbiter waits in RESP indefinitely, and err only reflects mem_resp_err.

Test Plan:
- IFU read alone, addr 0x8000_0000, zero-wait memory returns 0x0000_0413 → ifu_req_ready in cycle 0; mem_req_valid in cycle 1 with wen = 0; ifu_resp_valid with rdata 0x0000_0413 in cycle 2; lsu_resp_valid stays 0.
- IFU and LSU valid in the same cycle (LSU store addr 0x8000_0100, wdata 0xDEADBEEF, wmask 0xF) → LSU granted; mem_wen = 1 with matching fields; IFU granted only after the LSU response handshake.
- Memory holds mem_req_ready = 0 for 5 cycles → mem_req_valid and mem_addr stay constant; both req_ready outputs stay 0.
- LSU holds lsu_resp_ready = 0 for 3 cycles with mem_resp_valid = 1 → mem_resp_ready = 0 for those cycles; one handshake when ready rises; then IDLE.
- rst_n pulsed low while in RESP → all outputs are 0 asynchronously and no response is delivered. The next IFU request completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, memory never responds → owner sees resp_valid = 1, err = 1, rdata = 0 after 4 RESP cycles. A late mem_resp_valid is absorbed and not forwarded.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: IFU request/response, LSU request/response
// and the shared memory port.
//   master : the requesters plus the memory (drives requests, responses, readies)
//   slave  : the arbiter (drives grants, the memory request and forwarded responses)
`timescale 1ns/1ps
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  // IFU (read-only)
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_resp_err;

  // LSU (read/write)
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_resp_err;

  // Memory / bus bridge
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp_err;

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
  );

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the IFU (reads) and the LSU
// (reads/writes), one outstanding transaction at a time, LSU has fixed priority.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_bus_arbiter_if.slave (IFU, LSU and memory channels)
// Request grants and the response path are combinational; the memory request
// fields come from registers latched at grant time.
// Optional: define MEM_ARB_TIMEOUT_EN to time out a response after
// TIMEOUT_CYCLES cycles in RESP and return an error to the owner.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

  state_t   state_q, state_d;
  owner_t   owner_q, owner_d;
  mem_req_t req_q, req_d;

  logic              own_resp_ready_c;
  logic              resp_valid_c;
  logic              resp_err_c;
  logic [DATA_W-1:0] resp_rdata_c;
  logic              timeout_c;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;

  assign timeout_c = (state_q == RESP) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Response-wait counter and stale-response flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end
`else
  assign timeout_c = 1'b0;

  // TIMEOUT_CYCLES only matters for the timeout build
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
  end
`endif

  // State, owner and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  // Next state, grants and response routing
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    stale_d = stale_q;
`endif
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_resp_ready = 1'b0;
    resp_valid_c       = 1'b0;
    resp_err_c         = 1'b0;
    resp_rdata_c       = '0;
    own_resp_ready_c   = (owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

    case (state_q)
      IDLE: begin
        // Readies are gated with rst_n so nothing is granted while in reset
        bus.lsu_req_ready = bus.lsu_req_valid & rst_n;
        bus.ifu_req_ready = bus.ifu_req_valid & ~bus.lsu_req_valid & rst_n;
        if (bus.lsu_req_valid) begin
          owner_d = OWN_LSU;
          req_d   = '{addr: bus.lsu_addr, wen: bus.lsu_wen,
                      wdata: bus.lsu_wdata, wmask: bus.lsu_wmask};
          state_d = REQ;
        end else if (bus.ifu_req_valid) begin
          owner_d = OWN_IFU;
          req_d   = '{addr: bus.ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
          state_d = REQ;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Swallow the late response of a timed-out transaction
        bus.mem_resp_ready = stale_q & rst_n;
        if (stale_q && bus.mem_resp_valid) stale_d = 1'b0;
`endif
      end

      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      RESP: begin
        if (timeout_c) begin
          // Internal error response; memory is not acknowledged
          resp_valid_c = 1'b1;
          resp_err_c   = 1'b1;
          if (own_resp_ready_c) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
`ifdef MEM_ARB_TIMEOUT_EN
            stale_d = 1'b1;
`endif
          end
        end else begin
          resp_valid_c       = bus.mem_resp_valid;
          resp_rdata_c       = bus.mem_rdata;
          resp_err_c         = bus.mem_resp_err;
          bus.mem_resp_ready = own_resp_ready_c;
          if (bus.mem_resp_valid && own_resp_ready_c) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (!bus.mem_resp_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Response goes only to the owner; the other side sees zeros
  assign bus.ifu_resp_valid = resp_valid_c & (owner_q == OWN_IFU);
  assign bus.ifu_resp_err   = resp_err_c   & (owner_q == OWN_IFU);
  assign bus.ifu_rdata      = (owner_q == OWN_IFU) ? resp_rdata_c : '0;
  assign bus.lsu_resp_valid = resp_valid_c & (owner_q == OWN_LSU);
  assign bus.lsu_resp_err   = resp_err_c   & (owner_q == OWN_LSU);
  assign bus.lsu_rdata      = (owner_q == OWN_LSU) ? resp_rdata_c : '0;

  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wen   = req_q.wen;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_wmask = req_q.wmask;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a cycle-by-cycle vector table covering
// single fetch, LSU-over-IFU priority, request stall and response backpressure,
// followed by hand-written async-reset and (optional) timeout sequences.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  localparam logic [31:0] A_I  = 32'h8000_0000;
  localparam logic [31:0] A_L  = 32'h8000_0100;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;
  localparam logic [31:0] RD_A = 32'h0000_0413;
  localparam logic [31:0] RD_B = 32'hCAFE_F00D;

  logic clk = 1'b0;
  logic rst_n;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // exp bits: {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen,
  //            mem_resp_ready, ifu_resp_valid, lsu_resp_valid}
  typedef struct {
    logic       ifu_v, lsu_v, wen, mrq, mrs, ifu_rr, lsu_rr;
    logic [6:0] exp;
    logic [31:0] eaddr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  int   vecs = 0;
  int   bad  = 0;

  function automatic vec_t mk(input logic a, b, c, d, e, f, g,
                              input logic [6:0] x, input logic [31:0] ea);
    vec_t v;
    v.ifu_v = a; v.lsu_v = b; v.wen = c; v.mrq = d; v.mrs = e;
    v.ifu_rr = f; v.lsu_rr = g; v.exp = x; v.eaddr = ea;
    return v;
  endfunction

  task automatic drive(input logic a, b, c, d, e, f, g);
    bus.ifu_req_valid  = a;
    bus.lsu_req_valid  = b;
    bus.lsu_wen        = c;
    bus.mem_req_ready  = d;
    bus.mem_resp_valid = e;
    bus.ifu_resp_ready = f;
    bus.lsu_resp_ready = g;
  endtask

  task automatic check(input string name, input logic [6:0] exp, input logic [31:0] ea,
                       input logic [31:0] erd, input logic eerr);
    logic [6:0]  got;
    logic [31:0] w_ird, w_lrd;
    logic        w_ie, w_le, ok;
    got   = {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, bus.mem_wen,
             bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid};
    w_ird = exp[1] ? erd : 32'h0;
    w_ie  = exp[1] ? eerr : 1'b0;
    w_lrd = exp[0] ? erd : 32'h0;
    w_le  = exp[0] ? eerr : 1'b0;
    ok = (got === exp) && (bus.mem_addr === ea) &&
         (bus.ifu_rdata === w_ird) && (bus.ifu_resp_err === w_ie) &&
         (bus.lsu_rdata === w_lrd) && (bus.lsu_resp_err === w_le);
    if (exp[4] && exp[3])
      ok = ok && (bus.mem_wdata === WD) && (bus.mem_wmask === 4'hF);
    vecs++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got ctl=%b addr=%h ird=%h ie=%b lrd=%h le=%b wd=%h wm=%h ; want ctl=%b addr=%h ird=%h ie=%b lrd=%h le=%b",
               name, got, bus.mem_addr, bus.ifu_rdata, bus.ifu_resp_err, bus.lsu_rdata,
               bus.lsu_resp_err, bus.mem_wdata, bus.mem_wmask, exp, ea, w_ird, w_ie, w_lrd, w_le);
    end
  endtask

  task automatic step(input string name, input logic a, b, c, d, e, f, g,
                      input logic [6:0] exp, input logic [31:0] ea,
                      input logic [31:0] erd, input logic eerr);
    @(negedge clk);
    drive(a, b, c, d, e, f, g);
    #1;
    check(name, exp, ea, erd, eerr);
  endtask

  initial begin
    // IFU fetch alone
    tbl[0]  = mk(1,0,0,0,0,0,0, 7'b1000000, 32'h0);
    tbl[1]  = mk(0,0,0,1,0,0,0, 7'b0010000, A_I);
    tbl[2]  = mk(0,0,0,0,1,1,0, 7'b0000110, A_I);
    tbl[3]  = mk(0,0,0,0,0,0,0, 7'b0000000, A_I);
    // IFU and LSU store together: LSU wins, IFU waits
    tbl[4]  = mk(1,1,1,0,0,0,0, 7'b0100000, A_I);
    tbl[5]  = mk(1,0,0,1,0,0,0, 7'b0011000, A_L);
    tbl[6]  = mk(1,0,0,0,1,0,1, 7'b0001101, A_L);
    tbl[7]  = mk(1,0,0,0,0,0,0, 7'b1001000, A_L);
    // Memory stalls the IFU request for 5 cycles
    for (int i = 8; i <= 12; i++)
      tbl[i] = mk(1,1,1,0,0,0,0, 7'b0010000, A_I);
    tbl[13] = mk(0,0,0,1,0,0,0, 7'b0010000, A_I);
    tbl[14] = mk(0,0,0,0,1,1,0, 7'b0000110, A_I);
    // LSU load with 3 cycles of response backpressure
    tbl[15] = mk(0,1,0,0,0,0,0, 7'b0100000, A_I);
    tbl[16] = mk(0,0,0,1,0,0,0, 7'b0010000, A_L);
    for (int i = 17; i <= 19; i++)
      tbl[i] = mk(0,0,0,0,1,0,0, 7'b0000001, A_L);
    tbl[20] = mk(0,0,0,0,1,0,1, 7'b0000101, A_L);
    tbl[21] = mk(0,0,0,0,0,0,0, 7'b0000000, A_L);

    bus.ifu_addr     = A_I;
    bus.lsu_addr     = A_L;
    bus.lsu_wdata    = WD;
    bus.lsu_wmask    = 4'hF;
    bus.mem_rdata    = RD_A;
    bus.mem_resp_err = 1'b0;
    rst_n = 1'b0;
    drive(1,0,0,0,0,0,0);

    // Reset state: a valid IFU request must not be granted in reset
    repeat (2) @(negedge clk);
    #1;
    check("reset", 7'b0000000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0,0,0,0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].ifu_v, tbl[i].lsu_v, tbl[i].wen, tbl[i].mrq, tbl[i].mrs,
            tbl[i].ifu_rr, tbl[i].lsu_rr);
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].eaddr, RD_A, 1'b0);
    end

    // Asynchronous reset while a response is pending
    bus.mem_rdata = RD_B;
    step("rst_accept", 1,0,0,0,0,0,0, 7'b1000000, A_L, RD_B, 1'b0);
    step("rst_req",    0,0,0,1,0,0,0, 7'b0010000, A_I, RD_B, 1'b0);
    step("rst_resp",   0,0,0,0,1,0,0, 7'b0000010, A_I, RD_B, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.ifu_req_valid = 1'b1;
    #1;
    check("rst_async", 7'b0000000, 32'h0, 32'h0, 1'b0);
    step("rst_release", 1,0,0,0,1,1,0, 7'b0000000, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 7'b1000000, 32'h0, 32'h0, 1'b0);
    step("post_rst_req", 0,0,0,1,0,0,0, 7'b0010000, A_I, RD_B, 1'b0);
    bus.mem_resp_err = 1'b1;
    step("post_rst_resp", 0,0,0,0,1,1,0, 7'b0000110, A_I, RD_B, 1'b1);
    bus.mem_resp_err = 1'b0;
    step("post_rst_done", 0,0,0,0,0,0,0, 7'b0000000, A_I, RD_B, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: error response after TO RESP cycles, late answer dropped
    step("to_accept", 1,0,0,0,0,0,0, 7'b1000000, A_I, 32'h0, 1'b0);
    step("to_req",    0,0,0,1,0,0,0, 7'b0010000, A_I, 32'h0, 1'b0);
    for (int i = 0; i < int'(TO); i++)
      step($sformatf("to_wait%0d", i), 0,0,0,0,0,1,0, 7'b0000000, A_I, 32'h0, 1'b0);
    step("to_err",    0,0,0,0,0,1,0, 7'b0000010, A_I, 32'h0, 1'b1);
    step("to_stale",  0,0,0,0,1,0,0, 7'b0000100, A_I, 32'h0, 1'b0);
    step("to_clear",  0,0,0,0,0,0,0, 7'b0000000, A_I, 32'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
